// File: rtl/rv32im_muldiv_pkg.sv
// Shared decoder constants for the RV32 M-extension (MUL/DIV/REM) opcodes.
package rv32im_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

endpackage

// File: rtl/rv32im_muldiv_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
module rv32im_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // A set carry-out bit means the shifted remainder already exceeds any divisor;
  // the W-bit modular subtract is then still exact.
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_qbit    = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_div);
    w_rem_nxt = w_qbit ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
  end

  // Results are presented during the final iteration cycle so the parent can
  // register them on the same edge that completes the division.
  assign o_done      = r_run & (r_cnt == CW'(WIDTH-1));
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
    end else if (r_run) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/rv32im_muldiv.sv
// M-extension execute unit: fixed-latency multiply, iterative divide, valid/ready issue.
module rv32im_muldiv
  import rv32im_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] MCNT_LAST = MUL_LATENCY - 2;

  logic [1:0]       r_state, w_state_nxt;
  logic [31:0]      r_mcnt;
  logic [WIDTH-1:0] r_result, r_mul_res;
  logic             r_neg_q, r_neg_r, r_is_rem;

  logic             w_accept, w_is_div, w_is_rem, w_div_signed;
  logic             w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
  logic [WIDTH-1:0] w_spec_res, w_mul_res, w_res_nxt;
  logic [WIDTH-1:0] w_dvd, w_dvs, w_quo, w_rem, w_quo_fix, w_rem_fix;
  logic             w_a_sgn, w_b_sgn, w_div_done;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;

  assign o_ready  = (r_state == S_IDLE) | (r_state == S_DONE);
  assign o_busy   = (r_state == S_MUL) | (r_state == S_DIV);
  assign o_valid  = (r_state == S_DONE);
  assign o_result = r_result;
  assign w_accept = i_valid & o_ready & ~i_flush;

  always_comb begin
    w_is_div     = f3_is_div(i_funct3);
    w_is_rem     = f3_is_rem(i_funct3);
    w_div_signed = w_is_div & ~i_funct3[0];
    w_a_neg      = w_div_signed & i_rs1_data[WIDTH-1];
    w_b_neg      = w_div_signed & i_rs2_data[WIDTH-1];
    w_div0       = (i_rs2_data == '0);
    w_ovf        = w_div_signed & (i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) & (i_rs2_data == '1);
    w_special    = w_is_div & (w_div0 | w_ovf);
    if (w_div0) w_spec_res = w_is_rem ? i_rs1_data : '1;
    else        w_spec_res = w_is_rem ? '0 : i_rs1_data;
    w_dvd = w_a_neg ? (-i_rs1_data) : i_rs1_data;
    w_dvs = w_b_neg ? (-i_rs2_data) : i_rs2_data;
  end

  // Extending to 2*WIDTH bits yields the same low 2*WIDTH product bits as the
  // (2*WIDTH+2)-bit signed product of the (WIDTH+1)-bit extended operands.
  always_comb begin
    w_a_sgn   = (i_funct3 != FUNCT3_MULHU);
    w_b_sgn   = (i_funct3 == FUNCT3_MUL) | (i_funct3 == FUNCT3_MULH);
    w_a_ext   = {{WIDTH{w_a_sgn & i_rs1_data[WIDTH-1]}}, i_rs1_data};
    w_b_ext   = {{WIDTH{w_b_sgn & i_rs2_data[WIDTH-1]}}, i_rs2_data};
    w_prod    = w_a_ext * w_b_ext;
    w_mul_res = (i_funct3 == FUNCT3_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  end

  rv32im_divider #(.WIDTH(WIDTH)) u_div (
    .i_clk       (i_clk),
    .i_clear     (i_rst | i_flush),
    .i_start     (w_accept & w_is_div & ~w_special),
    .i_dividend  (w_dvd),
    .i_divisor   (w_dvs),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_done      (w_div_done)
  );

  assign w_quo_fix = r_neg_q ? (-w_quo) : w_quo;
  assign w_rem_fix = r_neg_r ? (-w_rem) : w_rem;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (w_is_div)              w_state_nxt = w_special ? S_DONE : S_DIV;
          else if (MUL_LATENCY == 1) w_state_nxt = S_DONE;
          else                       w_state_nxt = S_MUL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL:   if (r_mcnt == MCNT_LAST) w_state_nxt = S_DONE;
      S_DIV:   if (w_div_done) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    w_res_nxt = r_result;
    if (w_accept)                w_res_nxt = w_is_div ? w_spec_res : w_mul_res;
    else if (r_state == S_MUL)   w_res_nxt = r_mul_res;
    else if (r_state == S_DIV)   w_res_nxt = r_is_rem ? w_rem_fix : w_quo_fix;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_mcnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == S_DONE) r_result <= w_res_nxt;
      if (w_accept) begin
        r_mcnt    <= '0;
        r_mul_res <= w_mul_res;
        r_is_rem  <= w_is_rem;
        r_neg_q   <= w_div_signed & ~w_is_rem & (i_rs1_data[WIDTH-1] ^ i_rs2_data[WIDTH-1]);
        r_neg_r   <= w_is_rem & w_a_neg;
      end else if (r_state == S_MUL) begin
        r_mcnt <= r_mcnt + 32'd1;
      end
    end
  end

endmodule
